// File: rtl/track_key_debounce.sv
// Six-track button debouncer: samples synchronized keys once per clk_2ms edge and
// produces clean levels, one-cycle press/release pulses and a long-press flag per track.
module track_key_debounce #(
    parameter int N_TRK      = 6,
    parameter int DEB_TICKS  = 5,
    parameter int HOLD_TICKS = 150
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_2ms,
    input  logic [N_TRK-1:0] key_raw,
    output logic [N_TRK-1:0] key_level,
    output logic [N_TRK-1:0] key_press,
    output logic [N_TRK-1:0] key_release,
    output logic [N_TRK-1:0] key_hold,
    output logic             any_press
);

    localparam int CNT_W  = $clog2(DEB_TICKS);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } trk_state_t;

    // Handshake: none. Inputs are free-running levels; outputs are registered
    // levels/pulses that a consumer samples every clk cycle without back-pressure.

    logic s1, s2, s3;
    logic tick;
    logic [N_TRK-1:0] key_m, key_s;

    // Per-track FSM state is kept in named arrays so checkers can bind to them.
    trk_state_t        state_q [N_TRK];
    trk_state_t        state_d [N_TRK];
    logic [CNT_W-1:0]  cnt_q   [N_TRK];
    logic [CNT_W-1:0]  cnt_d   [N_TRK];
    logic [HOLD_W-1:0] hold_q  [N_TRK];
    logic [HOLD_W-1:0] hold_d  [N_TRK];

    logic [N_TRK-1:0] level_d, press_d, release_d, hold_flag_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            key_m <= '0;
            key_s <= '0;
        end else begin
            s1    <= clk_2ms;
            s2    <= s1;
            s3    <= s2;
            key_m <= key_raw;
            key_s <= key_m;
        end
    end

    assign tick = s2 ^ s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TRK; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_hold    <= '0;
        end else begin
            for (int i = 0; i < N_TRK; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
            end
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_hold    <= hold_flag_d;
        end
    end

    always_comb begin
        press_d     = '0;
        release_d   = '0;
        level_d     = '0;
        hold_flag_d = key_hold;
        for (int i = 0; i < N_TRK; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hold_d[i]  = hold_q[i];
            if (tick) begin
                case (state_q[i])
                    IDLE: begin
                        if (key_s[i]) begin
                            state_d[i] = PRESS_WAIT;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!key_s[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = '0;
                            hold_d[i]  = '0;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!key_s[i]) begin
                            state_d[i] = RELEASE_WAIT;
                            cnt_d[i]   = CNT_W'(1);
                        end else if (hold_q[i] != HOLD_MAX) begin
                            // Saturating count; the flag latches on the tick it reaches the limit.
                            hold_d[i] = hold_q[i] + HOLD_W'(1);
                            if (hold_d[i] == HOLD_MAX) begin
                                hold_flag_d[i] = 1'b1;
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (key_s[i]) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i]     = IDLE;
                            cnt_d[i]       = '0;
                            hold_d[i]      = '0;
                            hold_flag_d[i] = 1'b0;
                            release_d[i]   = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
        end
    end

    assign any_press = |key_press;

endmodule

// File: tb/tb_track_key_debounce.sv
// Directed bench for track_key_debounce: steps clk_2ms by hand and checks pulse
// placement, bounce rejection, long-press flag and async reset behaviour.
module tb_track_key_debounce;

    logic       clk;
    logic       reset;
    logic       clk_2ms;
    logic [5:0] key_raw;
    logic [5:0] key_level, key_press, key_release, key_hold;
    logic       any_press;

    int total = 0;
    int bad   = 0;

    int   p_cnt [6];
    int   r_cnt [6];
    int   a_cnt;
    int   sync_err = 0;
    logic act;
    logic [5:0] prev_level, prev_hold;
    int   h_first;

    track_key_debounce #(
        .N_TRK(6),
        .DEB_TICKS(5),
        .HOLD_TICKS(150)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_2ms(clk_2ms),
        .key_raw(key_raw),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_hold(key_hold),
        .any_press(any_press)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 6; i++) begin
            p_cnt[i] = 0;
            r_cnt[i] = 0;
        end
        a_cnt = 0;
    endtask

    function automatic logic [5:0] p_vec();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = (p_cnt[i] != 0);
        return v;
    endfunction

    function automatic logic [5:0] r_vec();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = (r_cnt[i] != 0);
        return v;
    endfunction

    function automatic int p_sum();
        int s = 0;
        for (int i = 0; i < 6; i++) s += p_cnt[i];
        return s;
    endfunction

    // Sample n cycles on the falling edge, tallying pulses and cycle-alignment errors.
    task automatic watch(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (key_press[i]) p_cnt[i]++;
                if (key_release[i]) r_cnt[i]++;
                if (key_level[i] && !prev_level[i] && !key_press[i]) sync_err++;
                if (!key_level[i] && prev_level[i] && !key_release[i]) sync_err++;
                if (key_press[i] && !(key_level[i] && !prev_level[i])) sync_err++;
                if (key_release[i] && !(!key_level[i] && prev_level[i])) sync_err++;
                if (!key_hold[i] && prev_hold[i] && !key_release[i]) sync_err++;
            end
            if (any_press) a_cnt++;
            if (any_press !== (|key_press)) sync_err++;
            if (|{key_level, key_press, key_release, key_hold, any_press}) act = 1'b1;
            prev_level = key_level;
            prev_hold  = key_hold;
        end
    endtask

    // driver: one sample tick, keys applied well before the clk_2ms edge
    task automatic step(input logic [5:0] keys);
        clear_counts();
        key_raw = keys;
        watch(5);
        clk_2ms = ~clk_2ms;
        watch(5);
    endtask

    initial begin
        reset      = 1'b1;
        clk_2ms    = 1'b0;
        key_raw    = '0;
        prev_level = '0;
        prev_hold  = '0;
        act        = 1'b0;
        clear_counts();

        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", key_level, 6'h00);
        chk("rst_pulses", {key_press, key_release}, 12'h000);
        chk("rst_hold_any", {key_hold, any_press}, 7'h00);
        reset = 1'b1;

        // 1: idle ticks, then static clk_2ms with all keys down
        for (int k = 0; k < 40; k++) step(6'h00);
        chk("t1_idle_activity", act, 1'b0);
        clear_counts();
        key_raw = 6'h3F;
        watch(40);
        chk("t1_static_press", p_sum(), 0);
        chk("t1_static_activity", act, 1'b0);
        key_raw = 6'h00;
        watch(5);

        // 2: track 0 press on the 5th tick, then release on the 5th tick
        for (int k = 1; k <= 5; k++) begin
            step(6'h01);
            chk($sformatf("t2_press_tick%0d", k), p_vec(), (k == 5) ? 6'h01 : 6'h00);
        end
        chk("t2_press_single", p_cnt[0], 1);
        chk("t2_level", key_level, 6'h01);
        for (int k = 1; k <= 5; k++) begin
            step(6'h00);
            chk($sformatf("t2_rel_tick%0d", k), r_vec(), (k == 5) ? 6'h01 : 6'h00);
        end
        chk("t2_level_after_rel", key_level, 6'h00);

        // 3: bounce on track 2 -> one press on the 5th tick of the final run
        for (int k = 1; k <= 3; k++) begin
            step(6'h04);
            chk($sformatf("t3_bounce_hi%0d", k), p_vec(), 6'h00);
        end
        step(6'h00);
        chk("t3_bounce_lo", p_vec(), 6'h00);
        for (int k = 1; k <= 5; k++) begin
            step(6'h04);
            chk($sformatf("t3_run_tick%0d", k), p_vec(), (k == 5) ? 6'h04 : 6'h00);
        end
        chk("t3_level", key_level, 6'h04);
        for (int k = 1; k <= 5; k++) step(6'h00);
        chk("t3_rel_done", {key_level, key_hold}, 12'h000);

        // 4: long press on track 1, flag on tick 150 after the press tick (step 155)
        h_first = 0;
        for (int k = 1; k <= 160; k++) begin
            step(6'h02);
            if (key_hold[1] && h_first == 0) h_first = k;
        end
        chk("t4_hold_step", h_first, 155);
        chk("t4_hold_vec", key_hold, 6'h02);
        for (int k = 1; k <= 5; k++) begin
            step(6'h00);
            chk($sformatf("t4_rel_tick%0d", k), r_vec(), (k == 5) ? 6'h02 : 6'h00);
            if (k == 4) chk("t4_hold_kept_in_rw", {key_level[1], key_hold[1]}, 2'b11);
        end
        chk("t4_after_rel", {key_level[1], key_hold[1]}, 2'b00);

        // 5: short dropout while track 3 is long-pressed
        for (int k = 1; k <= 155; k++) step(6'h08);
        chk("t5_hold_set", key_hold, 6'h08);
        clear_counts();
        step(6'h00);
        chk("t5_drop1_rel", r_vec(), 6'h00);
        step(6'h00);
        chk("t5_drop2_rel", r_vec(), 6'h00);
        for (int k = 1; k <= 3; k++) begin
            step(6'h08);
            chk($sformatf("t5_back%0d_pulses", k), {p_vec(), r_vec()}, 12'h000);
        end
        chk("t5_level_hold", {key_level[3], key_hold[3]}, 2'b11);

        // 6: all keys down, reset mid-debounce, then a common press
        for (int k = 1; k <= 3; k++) begin
            step(6'h3F);
            chk($sformatf("t6_pre%0d_press", k), p_vec(), 6'h00);
        end
        chk("t6_pre_state", {key_level, key_hold}, {6'h08, 6'h08});
        reset = 1'b0;
        #1;
        chk("t6_rst_level_hold", {key_level, key_hold}, 12'h000);
        chk("t6_rst_pulses_any", {key_press, key_release, any_press}, 13'h0000);
        clk_2ms = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        prev_level = key_level;
        prev_hold  = key_hold;
        for (int k = 1; k <= 5; k++) begin
            step(6'h3F);
            chk($sformatf("t6_press_tick%0d", k), p_vec(), (k == 5) ? 6'h3F : 6'h00);
            chk($sformatf("t6_any_tick%0d", k), a_cnt, (k == 5) ? 1 : 0);
        end
        chk("t6_press_single", p_sum(), 6);
        chk("t6_level", key_level, 6'h3F);

        chk("alignment_errors", sync_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
